// File: rtl/mem_load_ctrl_if.sv
// Data-memory bus between the MEM-stage controller (master) and the memory (slave).
// Handshake: the master raises req with we/addr/be/wdata stable and holds them
// until the slave answers with a single-cycle ack; rdata is valid in the ack cycle.
interface mem_load_ctrl_if #(
  parameter int ADDR_W = 32
);
  logic              req;
  logic              we;
  logic [ADDR_W-1:0] addr;
  logic [3:0]        be;
  logic [31:0]       wdata;
  logic              ack;
  logic [31:0]       rdata;

  modport master (
    output req, we, addr, be, wdata,
    input  ack, rdata
  );

  modport slave (
    input  req, we, addr, be, wdata,
    output ack, rdata
  );
endinterface

// File: rtl/mem_load_ctrl.sv
// MEM-stage data-memory access controller: accepts one load/store, runs it on
// the req/ack data bus, formats load data for write-back and pulses mem_stop_end
// to release the load-use fetch stall.
// Optional build macro: MEM_ALIGN_CHECK_EN (misaligned half/word ops abort
// without touching the bus).
// Upstream handshake: an op transfers when mem_valid & mem_ready; mem_ready is
// high only in IDLE, and mem_valid outside IDLE is ignored.
module mem_load_ctrl #(
  parameter int ADDR_W      = 32,
  parameter int ACK_TIMEOUT = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              mem_valid,
  output logic              mem_ready,
  input  logic [2:0]        mem_op,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic [31:0]       mem_wdata,
  input  logic [4:0]        mem_rd,
  mem_load_ctrl_if.master   bus,
  output logic              wb_we,
  output logic [4:0]        wb_rd,
  output logic [31:0]       wb_data,
  output logic              mem_stop_end,
  output logic              mem_busy,
  output logic              bus_err,
  output logic [1:0]        state_dbg
);

  localparam int CNT_W = $clog2(ACK_TIMEOUT + 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [2:0]        op_q;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0]       wdata_q;
  logic [4:0]        rd_q;
  logic [CNT_W-1:0]  cnt_q;
  logic              abort_q;
  logic [4:0]        wb_rd_q;
  logic [31:0]       wb_data_q;
  logic              misalign;
  logic              timeout;
  logic              op_is_load;

  // Byte enables for the latched op: byte ops pick one lane, halves pick a pair.
  function automatic logic [3:0] calc_be(input logic [2:0] op, input logic [1:0] a);
    case (op)
      3'd0, 3'd3, 3'd5: calc_be = 4'b0001 << a;
      3'd1, 3'd4, 3'd6: calc_be = a[1] ? 4'b1100 : 4'b0011;
      default:          calc_be = 4'b1111;
    endcase
  endfunction

  // Store data replicated across lanes so the enabled lanes always see it.
  function automatic logic [31:0] calc_wdata(input logic [2:0] op, input logic [31:0] w);
    case (op)
      3'd5:    calc_wdata = {4{w[7:0]}};
      3'd6:    calc_wdata = {2{w[15:0]}};
      default: calc_wdata = w;
    endcase
  endfunction

  // Lane select plus sign/zero extension of the returned word.
  function automatic logic [31:0] fmt_load(input logic [2:0] op, input logic [1:0] a,
                                           input logic [31:0] r);
    logic [7:0]  b;
    logic [15:0] h;
    b = r[{a, 3'b000} +: 8];
    h = a[1] ? r[31:16] : r[15:0];
    case (op)
      3'd0:    fmt_load = {{24{b[7]}}, b};
      3'd3:    fmt_load = {24'd0, b};
      3'd1:    fmt_load = {{16{h[15]}}, h};
      3'd4:    fmt_load = {16'd0, h};
      default: fmt_load = r;
    endcase
  endfunction

`ifdef MEM_ALIGN_CHECK_EN
  // Half ops need addr[0]==0, word ops need addr[1:0]==0.
  assign misalign = ((mem_op == 3'd1 || mem_op == 3'd4 || mem_op == 3'd6) && mem_addr[0]) ||
                    ((mem_op == 3'd2 || mem_op == 3'd7) && (mem_addr[1:0] != 2'b00));
`else
  assign misalign = 1'b0;
`endif

  assign timeout    = (cnt_q == CNT_W'(ACK_TIMEOUT - 1));
  assign op_is_load = (op_q <= 3'd4);

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= S_IDLE;
    else      state_q <= state_d;
  end

  // Next-state logic: ack beats a simultaneous timeout.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (mem_valid) state_d = misalign ? S_DONE : S_REQ;
      S_REQ:   if (bus.ack || timeout) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Op latch, timeout counter, abort flag and write-back capture.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      op_q      <= 3'd0;
      addr_q    <= '0;
      wdata_q   <= 32'd0;
      rd_q      <= 5'd0;
      cnt_q     <= '0;
      abort_q   <= 1'b0;
      wb_rd_q   <= 5'd0;
      wb_data_q <= 32'd0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (mem_valid) begin
            op_q    <= mem_op;
            addr_q  <= mem_addr;
            wdata_q <= mem_wdata;
            rd_q    <= mem_rd;
            cnt_q   <= '0;
            abort_q <= misalign;
          end
        end
        S_REQ: begin
          if (bus.ack) begin
            abort_q <= 1'b0;
            if (op_is_load) begin
              wb_data_q <= fmt_load(op_q, addr_q[1:0], bus.rdata);
              wb_rd_q   <= rd_q;
            end
          end else if (timeout) begin
            abort_q <= 1'b1;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // Outputs decoded from the current state; bus fields are zero outside REQ.
  always_comb begin
    mem_ready    = 1'b0;
    mem_busy     = 1'b0;
    mem_stop_end = 1'b0;
    wb_we        = 1'b0;
    bus_err      = 1'b0;
    bus.req      = 1'b0;
    bus.we       = 1'b0;
    bus.addr     = '0;
    bus.be       = 4'b0000;
    bus.wdata    = 32'd0;
    case (state_q)
      S_IDLE: mem_ready = 1'b1;
      S_REQ: begin
        mem_busy  = 1'b1;
        bus.req   = 1'b1;
        bus.we    = ~op_is_load;
        bus.addr  = {addr_q[ADDR_W-1:2], 2'b00};
        bus.be    = calc_be(op_q, addr_q[1:0]);
        bus.wdata = calc_wdata(op_q, wdata_q);
      end
      S_DONE: begin
        mem_busy     = 1'b1;
        mem_stop_end = op_is_load;
        wb_we        = op_is_load & ~abort_q;
        bus_err      = abort_q;
      end
      default: ;
    endcase
  end

  assign wb_rd     = wb_rd_q;
  assign wb_data   = wb_data_q;
  assign state_dbg = state_q;

endmodule
